// File: rtl/cmp_word_sequencer_pkg.sv
// rtl/cmp_word_sequencer_pkg.sv - shared types, defaults and sizing helpers for the word sequencer
package cmp_word_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  localparam int DEF_WORD_BITS = 16;
  localparam int DEF_NUM_WORDS = 2;

  // Word index needs at least one bit even when there is only one word.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int op_width(input int w, input int n);
    return w * n;
  endfunction

endpackage

// File: rtl/cmp_word_sequencer_if.sv
// rtl/cmp_word_sequencer_if.sv - requester-side bundle for the shared wide comparator
interface cmp_word_sequencer_if
  import cmp_word_sequencer_pkg::*;
#(
  parameter int WORD_BITS = DEF_WORD_BITS,
  parameter int NUM_WORDS = DEF_NUM_WORDS
);

  localparam int OPW = op_width(WORD_BITS, NUM_WORDS);

  logic [1:0]     req;
  logic [OPW-1:0] a0;
  logic [OPW-1:0] b0;
  logic [OPW-1:0] a1;
  logic [OPW-1:0] b1;
  logic [1:0]     ack;
  logic           a_eq_b;
  logic           a_gt_b;
  logic           a_lt_b;
  logic           busy;
  logic           grant_id;

  modport master (
    output req, a0, b0, a1, b1,
    input  ack, a_eq_b, a_gt_b, a_lt_b, busy, grant_id
  );

  modport slave (
    input  req, a0, b0, a1, b1,
    output ack, a_eq_b, a_gt_b, a_lt_b, busy, grant_id
  );

endinterface

// File: rtl/cmp_word_sequencer_cmp.sv
// rtl/cmp_word_sequencer_cmp.sv - single-word magnitude comparator cell, signed or unsigned
module cmp_word_sequencer_cmp #(
  parameter int NR_OF_BITS = 16,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic [NR_OF_BITS-1:0] data_a_i,
  input  logic [NR_OF_BITS-1:0] data_b_i,
  output logic                  a_eq_b_o,
  output logic                  a_gt_b_o,
  output logic                  a_lt_b_o
);

  assign a_eq_b_o = (data_a_i == data_b_i);

  generate
    if (SIGNED_CMP) begin : g_signed
      assign a_gt_b_o = ($signed(data_a_i) > $signed(data_b_i));
      assign a_lt_b_o = ($signed(data_a_i) < $signed(data_b_i));
    end else begin : g_unsigned
      assign a_gt_b_o = (data_a_i > data_b_i);
      assign a_lt_b_o = (data_a_i < data_b_i);
    end
  endgenerate

endmodule

// File: rtl/cmp_word_sequencer_rr.sv
// rtl/cmp_word_sequencer_rr.sv - two-way round-robin arbiter; pointer names the favoured requester
module cmp_word_sequencer_rr (
  input  logic [1:0] req_i,
  input  logic       rr_ptr_i,
  output logic       valid_o,
  output logic       winner_o
);

  assign valid_o  = |req_i;
  assign winner_o = (req_i == 2'b11) ? rr_ptr_i : req_i[1];

endmodule

// File: rtl/cmp_word_sequencer.sv
// rtl/cmp_word_sequencer.sv - shares one word comparator between two requesters,
// sequencing wide compares most-significant word first with early exit
module cmp_word_sequencer
  import cmp_word_sequencer_pkg::*;
#(
  parameter int WORD_BITS       = DEF_WORD_BITS,
  parameter int NUM_WORDS       = DEF_NUM_WORDS,
  parameter bit TWOS_COMPLEMENT = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  cmp_word_sequencer_if.slave  bus
);

  localparam int OPW   = op_width(WORD_BITS, NUM_WORDS);
  localparam int IDX_W = idx_width(NUM_WORDS);
  localparam logic [IDX_W-1:0] MS_IDX = IDX_W'(NUM_WORDS - 1);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OPW-1:0]   opa_q, opa_d;
  logic [OPW-1:0]   opb_q, opb_d;
  logic             grant_q, grant_d;
  logic             rr_q, rr_d;
  logic [1:0]       ack_q, ack_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  logic                 arb_valid;
  logic                 arb_winner;
  logic [WORD_BITS-1:0] word_a;
  logic [WORD_BITS-1:0] word_b;
  logic                 s_eq, s_gt, s_lt;
  logic                 u_eq, u_gt, u_lt;
  logic                 is_ms;
  logic                 cmp_eq, cmp_gt, cmp_lt;

  cmp_word_sequencer_rr u_rr (
    .req_i    (bus.req),
    .rr_ptr_i (rr_q),
    .valid_o  (arb_valid),
    .winner_o (arb_winner)
  );

  always_comb begin
    word_a = '0;
    word_b = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        word_a = opa_q[i*WORD_BITS +: WORD_BITS];
        word_b = opb_q[i*WORD_BITS +: WORD_BITS];
      end
    end
  end

  // Only the most-significant word carries the sign; lower words are plain magnitudes.
  cmp_word_sequencer_cmp #(
    .NR_OF_BITS (WORD_BITS),
    .SIGNED_CMP (TWOS_COMPLEMENT)
  ) u_cmp_ms (
    .data_a_i (word_a),
    .data_b_i (word_b),
    .a_eq_b_o (s_eq),
    .a_gt_b_o (s_gt),
    .a_lt_b_o (s_lt)
  );

  cmp_word_sequencer_cmp #(
    .NR_OF_BITS (WORD_BITS),
    .SIGNED_CMP (1'b0)
  ) u_cmp_ls (
    .data_a_i (word_a),
    .data_b_i (word_b),
    .a_eq_b_o (u_eq),
    .a_gt_b_o (u_gt),
    .a_lt_b_o (u_lt)
  );

  assign is_ms  = (idx_q == MS_IDX);
  assign cmp_eq = is_ms ? s_eq : u_eq;
  assign cmp_gt = is_ms ? s_gt : u_gt;
  assign cmp_lt = is_ms ? s_lt : u_lt;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    ack_d   = '0;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          opa_d   = arb_winner ? bus.a1 : bus.a0;
          opb_d   = arb_winner ? bus.b1 : bus.b0;
          grant_d = arb_winner;
          idx_d   = MS_IDX;
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        if (!cmp_eq) begin
          eq_d           = 1'b0;
          gt_d           = cmp_gt;
          lt_d           = cmp_lt;
          ack_d[grant_q] = 1'b1;
          state_d        = ST_DONE;
        end else if (idx_q == '0) begin
          eq_d           = 1'b1;
          gt_d           = 1'b0;
          lt_d           = 1'b0;
          ack_d[grant_q] = 1'b1;
          state_d        = ST_DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      ST_DONE: begin
        rr_d    = ~grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      grant_q <= 1'b0;
      rr_q    <= 1'b0;
      ack_q   <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      ack_q   <= ack_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.a_eq_b   = eq_q;
  assign bus.a_gt_b   = gt_q;
  assign bus.a_lt_b   = lt_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.grant_id = grant_q;

endmodule
